mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single-ported memory model between two requesters: the CPU memory port (cpu_*) and a host/debug port (dbg_*) used for program load and state dump.
- Sits in the CPU hierarchy between the CPU bus adapter, the debug loader and the memory.
- Grants one transaction at a time with round-robin fairness.
- Sequences each access through issue, read-wait and response phases.
- Locks out the CPU while halt is asserted.

Parameters:
- ADDR_W, 10, memory address width.
- DATA_W, 12, memory data width.
- RD_LAT, 1, cycles from mem_en (read) to valid mem_rdata; legal range 1..7.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- cpu_req  in  1  CPU request valid
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  ADDR_W  CPU address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  DATA_W  read data, valid while cpu_ack=1
- dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_ack, dbg_rdata: same as the cpu_* ports, for the debug port
- halt  in  1  CPU halted; only the debug port is granted while high
- mem_en  out  1  memory access strobe
- mem_we  out  1  write enable, meaningful only when mem_en=1
- mem_addr  out  ADDR_W  address
- mem_wdata  out  DATA_W  write data
- mem_rdata  in  DATA_W  read data
- owner  out  2  current owner: 00 none, 01 cpu, 10 dbg
- busy  out  1  state != IDLE

Behaviour:
- States: IDLE, ISSUE, RWAIT, RESP.
- Reset values: state IDLE, every output 0, last_grant = dbg, so the CPU wins the first tie.
- Requester contract:
  - req and its fields stay stable from assertion until ack.
  - In the cycle after ack, the requester either drops req or presents a new request.
  - Any req change before ack is a protocol violation; the arbiter uses the fields latched at grant.
- IDLE, cycle N:
  - Eligible requests: dbg_req, and cpu_req & ~halt.
  - Both eligible: grant the requester other than last_grant.
  - One eligible: grant it.
  - On grant: latch we/addr/wdata, set owner, update last_grant, go to ISSUE.
- ISSUE (N+1):
  - mem_en=1 for exactly one cycle, with the latched fields on mem_we/mem_addr/mem_wdata.
  - Next state: write goes to RESP; read goes to RWAIT with a counter loaded to RD_LAT-1.
- RWAIT:
  - Counts down; when the counter reaches 0, capture mem_rdata into rdata_q and go to RESP.
  - Capture therefore happens in cycle N+1+RD_LAT.
- RESP:
  - Owner's ack=1 and owner's rdata = rdata_q; the other port's ack=0. Next state IDLE, owner cleared.
  - Write ack lands at N+2; read ack lands at N+2+RD_LAT.
- rdata outputs are 0 whenever their ack is 0. Write acks return rdata 0.
- Throughput: one transaction per 3 cycles (write) or 3+RD_LAT cycles (read). No overlap, no pipelining.
- Halt:
  - halt rising mid-transaction does not abort the transaction; a CPU access already granted completes and is acked.
  - While halt=1, cpu_req is never granted and cpu_ack stays 0.
  - When halt falls, the CPU becomes eligible again in the next IDLE evaluation.
- Starvation bound: with both ports continuously requesting, grants strictly alternate.
- Reset mid-transaction:
  - Returns to IDLE next cycle and clears every output.
  - Nothing is acked and any in-flight access is dropped.
  - Memory contents are not touched by the arbiter.
- Width rules: fields pass through unmodified. The RD_LAT counter is 3 bits.

Decomposition:
- Shared package (common_def):
  - arb_state_t enum {IDLE, ISSUE, RWAIT, RESP}
  - owner constants OWN_NONE=2'b00, OWN_CPU=2'b01, OWN_DBG=2'b10
  - default MEM_RD_LAT
- One natural sub-module: arb_rr_pick, a combinational two-way round-robin pick taking eligible[1:0] and last_grant and returning grant[1:0].
- FSM, latches and counter live in mem_port_arbiter.

Test Plan:
- Reset then CPU write addr=0x005 wdata=0x03C at N → ISSUE at N+1 with mem_en=1, mem_we=1, mem_addr=0x005, mem_wdata=0x03C; cpu_ack pulse at N+2; owner returns to 00 at N+3.
- RD_LAT=2, dbg read addr=0x3FF with the memory returning 0xABC → mem_en at N+1; dbg_ack=1 and dbg_rdata=0xABC at N+4; cpu_ack stays 0 throughout.
- cpu_req and dbg_req both held high for 6 transactions from reset → grant order cpu, dbg, cpu, dbg, cpu, dbg.
- halt=1 with both requesting → only dbg is granted across 4 transactions. halt=0 → the next grant goes to cpu.
- CPU read granted, then halt asserted the cycle after the grant → CPU read still completes and cpu_ack fires; following grants go to dbg only.
- rst asserted during RWAIT → next cycle state IDLE, mem_en=0, cpu_ack=0, dbg_ack=0, owner=00, busy=0; no ack for the aborted access.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the memory port arbiter: FSM states, owner codes and
// the default memory read latency.
package common_def;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RWAIT,
        RESP
    } arb_state_t;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_CPU  = 2'b01;
    localparam logic [1:0] OWN_DBG  = 2'b10;

    localparam int MEM_RD_LAT = 1;

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Two-way round-robin pick. Bit 0 is the CPU and bit 1 the debug port, so the
// one-hot grant doubles as the owner code.
module arb_rr_pick
    import common_def::*;
(
    input  logic [1:0] eligible,
    input  logic [1:0] last_grant,
    output logic [1:0] grant
);

    always_comb begin
        // NOTE: assign a default before any branch so no path leaves grant unassigned (no latch).
        grant = OWN_NONE;
        if (eligible == 2'b11) begin
            grant = (last_grant == OWN_CPU) ? OWN_DBG : OWN_CPU;
        end else begin
            grant = eligible;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between the CPU port and the debug port,
// one transaction at a time, sequenced IDLE -> ISSUE -> (RWAIT) -> RESP.
module mem_port_arbiter
    import common_def::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 12,
    parameter int RD_LAT = MEM_RD_LAT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] dbg_rdata,
    input  logic              halt,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        owner,
    output logic              busy
);

    arb_state_t  state;
    logic [1:0]  last_grant;
    logic [1:0]  eligible;
    logic [1:0]  grant;
    logic [2:0]  cnt;

    // A halted CPU is simply invisible to the picker.
    assign eligible = {dbg_req, cpu_req & ~halt};

    arb_rr_pick u_pick (
        .eligible   (eligible),
        .last_grant (last_grant),
        .grant      (grant)
    );

    // mem_we/mem_addr/mem_wdata double as the fields latched at grant.
    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= OWN_DBG;
            owner      <= OWN_NONE;
            busy       <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cnt        <= '0;
            cpu_ack    <= 1'b0;
            dbg_ack    <= 1'b0;
            cpu_rdata  <= '0;
            dbg_rdata  <= '0;
        end else begin
            mem_en    <= 1'b0;
            cpu_ack   <= 1'b0;
            dbg_ack   <= 1'b0;
            cpu_rdata <= '0;
            dbg_rdata <= '0;
            case (state)
                IDLE: begin
                    if (grant != OWN_NONE) begin
                        owner      <= grant;
                        last_grant <= grant;
                        busy       <= 1'b1;
                        mem_en     <= 1'b1;
                        state      <= ISSUE;
                        if (grant == OWN_CPU) begin
                            mem_we    <= cpu_we;
                            mem_addr  <= cpu_addr;
                            mem_wdata <= cpu_wdata;
                        end else begin
                            mem_we    <= dbg_we;
                            mem_addr  <= dbg_addr;
                            mem_wdata <= dbg_wdata;
                        end
                    end
                end
                ISSUE: begin
                    if (mem_we) begin
                        state   <= RESP;
                        cpu_ack <= (owner == OWN_CPU);
                        dbg_ack <= (owner == OWN_DBG);
                    end else begin
                        state <= RWAIT;
                        cnt   <= 3'(RD_LAT - 1);
                    end
                end
                RWAIT: begin
                    if (cnt == 3'd0) begin
                        state   <= RESP;
                        cpu_ack <= (owner == OWN_CPU);
                        dbg_ack <= (owner == OWN_DBG);
                        if (owner == OWN_CPU) begin
                            cpu_rdata <= mem_rdata;
                        end else begin
                            dbg_rdata <= mem_rdata;
                        end
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                    owner <= OWN_NONE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed and randomized requests
// checked against a transaction-level reference model and memory image.
module tb_mem_port_arbiter;
    import common_def::*;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 12;
    localparam int RD_LAT = 2;

    logic              clk;
    logic              rst;
    logic              cpu_req, cpu_we, dbg_req, dbg_we, halt;
    logic [ADDR_W-1:0] cpu_addr, dbg_addr;
    logic [DATA_W-1:0] cpu_wdata, dbg_wdata;
    logic              cpu_ack, dbg_ack;
    logic [DATA_W-1:0] cpu_rdata, dbg_rdata;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic [1:0]        owner;
    logic              busy;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ack   (cpu_ack),
        .cpu_rdata (cpu_rdata),
        .dbg_req   (dbg_req),
        .dbg_we    (dbg_we),
        .dbg_addr  (dbg_addr),
        .dbg_wdata (dbg_wdata),
        .dbg_ack   (dbg_ack),
        .dbg_rdata (dbg_rdata),
        .halt      (halt),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .owner     (owner),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory slave: read data appears RD_LAT cycles after the mem_en cycle.
    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rd_pipe [RD_LAT];

    always @(posedge clk) begin
        if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
        rd_pipe[0] <= (mem_en && !mem_we) ? mem[mem_addr] : 'x;
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rdata = rd_pipe[RD_LAT-1];

    // Reference model state.
    logic [DATA_W-1:0] ref_mem [2**ADDR_W];
    bit                ref_valid [2**ADDR_W];
    logic [1:0]        last_g;
    bit                cpu_en, dbg_en;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_port(input bit is_dbg);
        logic              we;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        we = 1'($urandom_range(0, 1));
        a  = ADDR_W'($urandom_range(0, 15));
        d  = DATA_W'($urandom);
        if (!we && !ref_valid[a]) we = 1'b1;
        if (is_dbg) begin
            dbg_req = dbg_en; dbg_we = we; dbg_addr = a; dbg_wdata = d;
        end else begin
            cpu_req = cpu_en; cpu_we = we; cpu_addr = a; cpu_wdata = d;
        end
    endtask

    // Called at a negedge of an IDLE cycle; runs one full transaction.
    task automatic one_txn(input bit halt_after);
        bit                el_c, el_d, is_dbg;
        logic [1:0]        exp_g;
        logic              we;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic [DATA_W-1:0] exp_rd;
        int                cyc;
        el_c = cpu_req && !halt;
        el_d = dbg_req;
        if (el_c && el_d) exp_g = (last_g == OWN_CPU) ? OWN_DBG : OWN_CPU;
        else              exp_g = el_c ? OWN_CPU : OWN_DBG;
        last_g = exp_g;
        is_dbg = (exp_g == OWN_DBG);
        we = is_dbg ? dbg_we    : cpu_we;
        a  = is_dbg ? dbg_addr  : cpu_addr;
        d  = is_dbg ? dbg_wdata : cpu_wdata;

        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!mem_en && cyc < 20);
        check("grant_latency", cyc, 1);
        check("owner", owner, exp_g);
        check("mem_we", mem_we, we);
        check("mem_addr", mem_addr, a);
        check("mem_wdata", mem_wdata, d);
        check("busy_active", busy, 1);
        if (halt_after) halt = 1'b1;

        cyc = 0;
        do begin @(negedge clk); cyc++; end while (!cpu_ack && !dbg_ack && cyc < 20);
        check("ack_latency", cyc, we ? 1 : 1 + RD_LAT);
        check("cpu_ack", cpu_ack, !is_dbg);
        check("dbg_ack", dbg_ack, is_dbg);
        exp_rd = we ? '0 : ref_mem[a];
        check("owner_rdata", is_dbg ? dbg_rdata : cpu_rdata, exp_rd);
        check("other_rdata", is_dbg ? cpu_rdata : dbg_rdata, 0);
        if (we) begin
            ref_mem[a]   = d;
            ref_valid[a] = 1'b1;
        end
        set_port(is_dbg);

        @(negedge clk);
        check("owner_cleared", owner, OWN_NONE);
        check("busy_cleared", busy, 0);
        check("acks_cleared", {cpu_ack, dbg_ack}, 0);
    endtask

    task automatic run_txns(input int n);
        for (int i = 0; i < n; i++) one_txn(1'b0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_mem_en"}, mem_en, 0);
        check({tag, "_acks"}, {cpu_ack, dbg_ack}, 0);
        check({tag, "_rdata"}, {cpu_rdata, dbg_rdata}, 0);
        check({tag, "_owner"}, owner, OWN_NONE);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_mem_fields"}, {mem_we, mem_addr, mem_wdata}, 0);
    endtask

    initial begin
        rst = 1'b1; halt = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
        cpu_en = 1'b0; dbg_en = 1'b0;
        last_g = OWN_DBG;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;

        // Directed CPU write.
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h005; cpu_wdata = 12'h03C;
        one_txn(1'b0);

        // Debug load then read-back of the top address.
        dbg_en = 1'b0;
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 10'h3FF; dbg_wdata = 12'hABC;
        one_txn(1'b0);
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 10'h3FF;
        one_txn(1'b0);

        // Both requesting continuously: grants must alternate.
        cpu_en = 1'b1; dbg_en = 1'b1;
        set_port(1'b0); set_port(1'b1);
        run_txns(6);

        // Halt locks the CPU out; release lets it back in.
        halt = 1'b1;
        run_txns(4);
        halt = 1'b0;
        cpu_we = 1'b0; cpu_addr = 10'h005;
        one_txn(1'b1);
        run_txns(3);
        halt = 1'b0;

        // Randomized batches.
        for (int b = 0; b < 10; b++) begin
            cpu_en = 1'($urandom_range(0, 1));
            dbg_en = 1'($urandom_range(0, 1));
            halt   = 1'($urandom_range(0, 3) == 0);
            if (!dbg_en && !(cpu_en && !halt)) dbg_en = 1'b1;
            set_port(1'b0); set_port(1'b1);
            run_txns(4);
        end
        halt = 1'b0;

        // Reset during RWAIT drops the access and restores the tie-break.
        cpu_en = 1'b1; dbg_en = 1'b0;
        dbg_req = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h005;
        @(negedge clk);
        check("abort_grant", {mem_en, owner}, {1'b1, OWN_CPU});
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_idle_outputs("midreset");
        rst = 1'b0;
        cpu_req = 1'b0;
        for (int i = 0; i < 2 * RD_LAT + 3; i++) begin
            @(negedge clk);
            check("no_ack_after_abort", {cpu_ack, dbg_ack, mem_en}, 0);
        end
        last_g = OWN_DBG;
        cpu_en = 1'b1; dbg_en = 1'b1;
        set_port(1'b0); set_port(1'b1);
        run_txns(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
